// File: rtl/alu_seq_pkg.sv
// Shared op-code constants and FSM state encoding for the sequential LEGv8 ALU.
// Imported by alu_seq and mul_shift_add; ALU_SEQ_MUL_EN selects whether MUL is built.
package alu_seq_pkg;

    localparam logic [3:0] ALU_AND    = 4'b0000;
    localparam logic [3:0] ALU_ORR    = 4'b0001;
    localparam logic [3:0] ALU_ADD    = 4'b0010;
    localparam logic [3:0] ALU_SUB    = 4'b0110;
    localparam logic [3:0] ALU_PASS_B = 4'b0111;
    localparam logic [3:0] ALU_NOR    = 4'b1100;
    localparam logic [3:0] ALU_MUL    = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/mul_shift_add.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per product.
// Only instantiated by alu_seq when ALU_SEQ_MUL_EN is defined.
module mul_shift_add
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand_in,
    input  logic [WIDTH-1:0] multiplier_in,
    output logic [WIDTH-1:0] product,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] multiplicand_reg;
    logic [WIDTH-1:0] multiplier_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [CW-1:0]    count_reg;
    logic             busy_reg;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] acc_next;

    assign addend   = multiplier_reg[0] ? multiplicand_reg : '0;
    assign acc_next = acc_reg + addend;

    // The final sum is exposed combinationally so the caller can register it
    // on the same edge that processes the last multiplier bit.
    assign product = acc_next;
    assign done    = busy_reg && (count_reg == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            multiplicand_reg <= '0;
            multiplier_reg   <= '0;
            acc_reg          <= '0;
            count_reg        <= '0;
            busy_reg         <= 1'b0;
        end else if (start) begin
            multiplicand_reg <= multiplicand_in;
            multiplier_reg   <= multiplier_in;
            acc_reg          <= '0;
            count_reg        <= '0;
            busy_reg         <= 1'b1;
        end else if (busy_reg) begin
            acc_reg          <= acc_next;
            multiplicand_reg <= multiplicand_reg << 1;
            multiplier_reg   <= multiplier_reg >> 1;
            count_reg        <= count_reg + CW'(1);
            if (count_reg == LAST) begin
                busy_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential LEGv8 execute-stage ALU with valid/ready handshake and registered result/zero.
// Define ALU_SEQ_MUL_EN to build the iterative MUL path; otherwise op 1001 yields 0 in one cycle.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready
);

    alu_state_e       state_reg;
    alu_state_e       state_next;
    logic [WIDTH-1:0] result_reg;
    logic [WIDTH-1:0] result_next;
    logic             zero_reg;
    logic             zero_next;
    logic             load_result;
    logic [WIDTH-1:0] alu_value;

`ifdef ALU_SEQ_MUL_EN
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    mul_shift_add #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (mul_start),
        .multiplicand_in (a),
        .multiplier_in   (b),
        .product         (mul_product),
        .done            (mul_done)
    );
`endif

    // Single-cycle datapath; MUL and unused codes fall to zero here.
    always_comb begin
        alu_value = '0;
        case (alu_control)
            ALU_AND:    alu_value = a & b;
            ALU_ORR:    alu_value = a | b;
            ALU_ADD:    alu_value = a + b;
            ALU_SUB:    alu_value = a - b;
            ALU_PASS_B: alu_value = b;
            ALU_NOR:    alu_value = ~(a | b);
            default:    alu_value = '0;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        zero_next   = zero_reg;
        load_result = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        mul_start   = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    if (alu_control == ALU_MUL) begin
                        mul_start  = 1'b1;
                        state_next = ST_MUL;
                    end else begin
                        result_next = alu_value;
                        load_result = 1'b1;
                        state_next  = ST_DONE;
                    end
`else
                    result_next = alu_value;
                    load_result = 1'b1;
                    state_next  = ST_DONE;
`endif
                end
            end
`ifdef ALU_SEQ_MUL_EN
            ST_MUL: begin
                if (mul_done) begin
                    result_next = mul_product;
                    load_result = 1'b1;
                    state_next  = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        // zero follows the result register and only moves when it loads
        if (load_result) begin
            zero_next = (result_next == '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            result_reg <= '0;
            zero_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            zero_reg   <= zero_next;
        end
    end

    assign result = result_reg;
    assign zero   = zero_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, reset/backpressure sequences,
// and random ops against a behavioural model. Follows ALU_SEQ_MUL_EN for MUL expectations.
module tb_alu_seq;

    localparam int W = 64;
`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_ON = 1'b1;
`else
    localparam bit MUL_ON = 1'b0;
`endif
    localparam int MUL_LAT = W + 1;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   alu_control = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         out_valid;
    logic         out_ready = 1'b0;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .alu_control (alu_control),
        .a           (a),
        .b           (b),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .result      (result),
        .zero        (zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    typedef struct {
        logic [3:0]  op;
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] exp;
        int          lat;
        int          hold;
    } vec_t;

    vec_t vecs[12];

    // Reference model: the op table as plain arithmetic.
    function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
        case (op)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b0111: return y;
            4'b1100: return ~(x | y);
            4'b1001: return MUL_ON ? (x * y) : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    function automatic int ref_lat(input logic [3:0] op);
        return (MUL_ON && op == 4'b1001) ? MUL_LAT : 1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [63:0] x,
                          input logic [63:0] y, input logic [63:0] exp, input int exp_lat,
                          input int hold);
        int lat;
        @(negedge clk);
        alu_control = op;
        a           = x;
        b           = y;
        in_valid    = 1'b1;
        chk({name, " in_ready_idle"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        // operands must have been captured at acceptance
        in_valid    = 1'b0;
        a           = {$urandom, $urandom};
        b           = {$urandom, $urandom};
        alu_control = 4'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, " latency"}, 64'(lat), 64'(exp_lat));
        chk({name, " result"}, result, exp);
        chk({name, " zero"}, 64'(zero), 64'(exp == 64'd0));
        chk({name, " in_ready_busy"}, 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({name, " held_result"}, result, exp);
            chk({name, " held_out_valid"}, 64'(out_valid), 64'd1);
            chk({name, " held_in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, " out_valid_after_ack"}, 64'(out_valid), 64'd0);
        chk({name, " in_ready_after_ack"}, 64'(in_ready), 64'd1);
        $display("txn %s op=%b a=%h b=%h -> result=%h zero=%b lat=%0d", name, op, x, y, result, zero, lat);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  ops[8];
        logic [3:0]  op;
        logic [63:0] x;
        logic [63:0] y;

        vecs[0]  = '{4'b0010, 64'd5, 64'd7, 64'd12, 1, 0};
        vecs[1]  = '{4'b0110, 64'h1234, 64'h1234, 64'd0, 1, 0};
        vecs[2]  = '{4'b0110, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0};
        vecs[3]  = '{4'b0001, 64'hF0, 64'h0F, 64'hFF, 1, 5};
        vecs[4]  = '{4'b0000, 64'hFF00_FF00, 64'h0FF0_0FF0, 64'h0F00_0F00, 1, 0};
        vecs[5]  = '{4'b1100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0};
        vecs[6]  = '{4'b1100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 1, 0};
        vecs[7]  = '{4'b0111, 64'hDEAD, 64'hBEEF_0000_0001, 64'hBEEF_0000_0001, 1, 1};
        vecs[8]  = '{4'b1111, 64'h55, 64'hAA, 64'd0, 1, 0};
        vecs[9]  = '{4'b1001, 64'h1_0000_0000, 64'h3_0000_0001,
                     MUL_ON ? 64'h1_0000_0000 : 64'd0, MUL_ON ? MUL_LAT : 1, 0};
        vecs[10] = '{4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
                     MUL_ON ? 64'hFFFF_FFFF_FFFF_FFFE : 64'd0, MUL_ON ? MUL_LAT : 1, 2};
        vecs[11] = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1, 0};

        ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0110;
        ops[4] = 4'b0111; ops[5] = 4'b1100; ops[6] = 4'b1001; ops[7] = 4'b0000;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset result", result, 64'd0);
        chk("reset zero", 64'(zero), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_reset in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].x, vecs[i].y,
                   vecs[i].exp, vecs[i].lat, vecs[i].hold);
        end

        // Reset in the middle of an operation (mid-MUL when built in)
        @(negedge clk);
        alu_control = MUL_ON ? 4'b1001 : 4'b0010;
        a           = 64'h1234;
        b           = 64'h10;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midop_reset out_valid", 64'(out_valid), 64'd0);
        chk("midop_reset result", result, 64'd0);
        chk("midop_reset zero", 64'(zero), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("midop_reset in_ready", 64'(in_ready), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("midop_reset no_stale_valid", 64'(out_valid), 64'd0);
        $display("txn midop_reset in_ready=%b out_valid=%b result=%h", in_ready, out_valid, result);
        run_op("after_reset_add", 4'b0010, 64'd5, 64'd7, 64'd12, 1, 0);

        // Randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            int k;
            k  = $urandom_range(0, 7);
            op = (k == 7) ? 4'($urandom) : ops[k];
            x  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
            y  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
            if ($urandom_range(0, 4) == 0) y = x;
            run_op($sformatf("rand%0d", i), op, x, y, ref_alu(op, x, y), ref_lat(op),
                   $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule
